// File: rtl/fxp_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative fixed-point multiplier among NREQ requesters.
// Optional macro FXP_ARB_FIXED_PRIO_EN: lowest requesting index always wins (no rotating pointer).
module fxp_mult_arbiter #(
   parameter int NREQ = 4,
   parameter int N    = 32,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_val,
   output logic [NREQ-1:0]   req_rdy,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [NREQ-1:0]   resp_val,
   input  logic [NREQ-1:0]   resp_rdy,
   output logic [N-1:0]      resp_c,
   output logic              mul_reset,
   output logic              mul_recv_val,
   input  logic              mul_recv_rdy,
   output logic [N-1:0]      mul_a,
   output logic [N-1:0]      mul_b,
   input  logic              mul_send_val,
   output logic              mul_send_rdy,
   input  logic [N-1:0]      mul_c,
   output logic              busy,
   output logic [IDW-1:0]    grant_id
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [IDW-1:0] id;
   logic [N-1:0]   op_a;
   logic [N-1:0]   op_b;
   logic [N-1:0]   res;
`ifndef FXP_ARB_FIXED_PRIO_EN
   logic [IDW-1:0] ptr;
`endif

   logic [N-1:0]   a_slice [NREQ];
   logic [N-1:0]   b_slice [NREQ];
   logic [IDW-1:0] win;
   logic           win_hit;
   logic           accept;

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign a_slice[g] = req_a[g*N +: N];
      assign b_slice[g] = req_b[g*N +: N];
   end

   // Arbitration: first asserted req_val scanning upward from the start index, wrapping.
   always_comb begin
      logic [IDW-1:0] idx;
      idx     = '0;
      win     = '0;
      win_hit = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef FXP_ARB_FIXED_PRIO_EN
         idx = IDW'(k);
`else
         idx = IDW'((int'(ptr) + k) % NREQ);
`endif
         if (!win_hit && req_val[idx]) begin
            win_hit = 1'b1;
            win     = idx;
         end else begin
            win_hit = win_hit;
         end
      end
   end

   assign accept = reset && (state == IDLE) && win_hit;

   // Next-state logic; only registered state and handshake inputs steer the FSM.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = ISSUE;
            else        state_next = IDLE;
         end
         ISSUE: begin
            if (mul_recv_rdy) state_next = WAIT;
            else              state_next = ISSUE;
         end
         WAIT: begin
            if (mul_send_val) state_next = RESP;
            else              state_next = WAIT;
         end
         RESP: begin
            if (resp_rdy[id]) state_next = IDLE;
            else              state_next = RESP;
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs; everything is forced to its reset value while reset is low.
   always_comb begin
      req_rdy      = '0;
      resp_val     = '0;
      resp_c       = '0;
      mul_recv_val = 1'b0;
      mul_send_rdy = 1'b0;
      if (accept) begin
         req_rdy[win] = 1'b1;
      end else begin
         req_rdy = '0;
      end
      if (reset && (state == RESP)) begin
         resp_val[id] = 1'b1;
         resp_c       = res;
      end else begin
         resp_val = '0;
      end
      mul_recv_val = reset && (state == ISSUE);
      mul_send_rdy = reset && (state == WAIT);
   end

   assign mul_reset = !reset;
   assign mul_a     = reset ? op_a : '0;
   assign mul_b     = reset ? op_b : '0;
   assign busy      = reset && (state != IDLE);
   assign grant_id  = reset ? id : '0;

   // State, operand, result and pointer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         id    <= '0;
         op_a  <= '0;
         op_b  <= '0;
         res   <= '0;
`ifndef FXP_ARB_FIXED_PRIO_EN
         ptr   <= '0;
`endif
      end else begin
         state <= state_next;
         if (accept) begin
            op_a <= a_slice[win];
            op_b <= b_slice[win];
            id   <= win;
         end
         if ((state == WAIT) && mul_send_val) begin
            res <= mul_c;
         end
`ifndef FXP_ARB_FIXED_PRIO_EN
         // The requester just served drops to lowest priority for the next grant.
         if ((state == RESP) && resp_rdy[id]) begin
            ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
         end
`endif
      end
   end

endmodule

// File: tb/tb_fxp_mult_arbiter.sv
// Self-checking bench for fxp_mult_arbiter with a behavioural iterative-multiplier stand-in.
module tb_fxp_mult_arbiter;
   localparam int NREQ = 4;
   localparam int N    = 32;
   localparam int IDW  = 2;
   localparam int FRAC = N / 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_val;
   logic [NREQ-1:0]   req_rdy;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ-1:0]   resp_val;
   logic [NREQ-1:0]   resp_rdy;
   logic [N-1:0]      resp_c;
   logic              mul_reset;
   logic              mul_recv_val;
   logic              mul_recv_rdy;
   logic [N-1:0]      mul_a;
   logic [N-1:0]      mul_b;
   logic              mul_send_val;
   logic              mul_send_rdy;
   logic [N-1:0]      mul_c;
   logic              busy;
   logic [IDW-1:0]    grant_id;

   int cyc = 0;
   int tests_run = 0;
   int fails = 0;
   int exp_ptr = 0;

   fxp_mult_arbiter #(.NREQ(NREQ), .N(N)) dut (
      .clk(clk), .reset(reset),
      .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_c(resp_c),
      .mul_reset(mul_reset), .mul_recv_val(mul_recv_val), .mul_recv_rdy(mul_recv_rdy),
      .mul_a(mul_a), .mul_b(mul_b), .mul_send_val(mul_send_val), .mul_send_rdy(mul_send_rdy),
      .mul_c(mul_c), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N-1:0] fx_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic signed [2*N-1:0] p;
      p = $signed(a) * $signed(b);
      return p[FRAC +: N];
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   // Expected winner: the arbitration rule applied directly to a request mask.
   function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
      int start;
`ifdef FXP_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = ptr;
`endif
      for (int k = 0; k < NREQ; k++) begin
         if (v[(start + k) % NREQ]) return (start + k) % NREQ;
      end
      return -1;
   endfunction

   // Multiplier stand-in: idle -> N compute cycles -> hold result until taken.
   int m_state = 0;
   int m_cnt = 0;
   logic [N-1:0] m_prod = '0;
   assign mul_recv_rdy = (m_state == 0);
   assign mul_send_val = (m_state == 2);
   assign mul_c        = (m_state == 2) ? m_prod : 32'hDEAD_BEEF;
   always @(posedge clk) begin
      if (mul_reset) begin
         m_state <= 0;
         m_cnt   <= 0;
      end else begin
         case (m_state)
            0: if (mul_recv_val) begin m_state <= 1; m_cnt <= N; m_prod <= fx_mul(mul_a, mul_b); end
            1: if (m_cnt == 1) m_state <= 2; else m_cnt <= m_cnt - 1;
            2: if (mul_send_rdy) m_state <= 0;
            default: m_state <= 0;
         endcase
      end
   end

   task automatic set_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b);
      req_a[idx*N +: N] = a;
      req_b[idx*N +: N] = b;
   endtask

   task automatic wait_rdy(input logic [NREQ-1:0] mask, output int t, output bit ok);
      ok = 1'b0; t = -1;
      for (int n = 0; n < 200; n++) begin
         #1;
         if ((req_rdy & mask) != '0) begin ok = 1'b1; t = cyc; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_resp(input logic [NREQ-1:0] mask, output int t, output bit ok);
      ok = 1'b0; t = -1;
      for (int n = 0; n < 200; n++) begin
         if ((resp_val & mask) != '0) begin ok = 1'b1; t = cyc; break; end
         @(negedge clk); #1;
      end
   endtask

   task automatic run_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int t, output int tr, output logic [N-1:0] c, output bit ok);
      bit ok1, ok2;
      @(negedge clk);
      set_op(idx, a, b);
      req_val = onehot(idx);
      wait_rdy(onehot(idx), t, ok1);
      @(posedge clk); #1;
      req_val = '0;
      wait_resp(onehot(idx), tr, ok2);
      c  = resp_c;
      ok = ok1 && ok2;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_val = '1; resp_rdy = '1;
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if ({req_rdy, resp_val, resp_c, mul_recv_val, mul_send_rdy, mul_a, mul_b, busy, grant_id} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: req_rdy=%b resp_val=%b resp_c=%h recv_val=%b send_rdy=%b mul_a=%h mul_b=%h busy=%b gid=%0d, all required 0",
                  req_rdy, resp_val, resp_c, mul_recv_val, mul_send_rdy, mul_a, mul_b, busy, grant_id);
      end
      tests_run++;
      if (mul_reset !== 1'b1) begin fails++; $display("FAIL reset_mul_reset: got %b want 1", mul_reset); end
   endtask

   task automatic test_contention();
      logic [N-1:0] opa [NREQ];
      logic [N-1:0] opb [NREQ];
      int t, tr, prev, w;
      bit ok;
      for (int i = 0; i < NREQ; i++) begin
         opa[i] = N'($urandom); opb[i] = N'($urandom); set_op(i, opa[i], opb[i]);
      end
      @(negedge clk);
      reset = 1'b1;
      prev = -1;
      for (int g = 0; g < 5; g++) begin
         wait_rdy('1, t, ok);
         w = pick(req_val, exp_ptr);
         tests_run++;
         if (!ok || req_rdy !== onehot(w)) begin
            fails++; $display("FAIL contention_grant%0d: req_rdy=%b want %b", g, req_rdy, onehot(w));
         end
         if (g > 0) begin
            tests_run++;
            if (t - prev != N + 4) begin fails++; $display("FAIL contention_interval%0d: got %0d want %0d", g, t - prev, N + 4); end
         end
         prev = t;
         @(posedge clk); #1;
         wait_resp(onehot(w), tr, ok);
         tests_run++;
         if (!ok || resp_c !== fx_mul(opa[w], opb[w]) || tr - t != N + 3) begin
            fails++; $display("FAIL contention_resp%0d: c=%h lat=%0d want c=%h lat=%0d", g, resp_c, tr - t, fx_mul(opa[w], opb[w]), N + 3);
         end
         exp_ptr = (w + 1) % NREQ;
         @(negedge clk);
      end
      req_val = '0;
   endtask

   task automatic test_single();
      int t, tr; logic [N-1:0] c; bit ok;
      run_op(1, 32'h0001_8000, 32'h0002_0000, t, tr, c, ok);
      tests_run++;
      if (!ok || c !== 32'h0003_0000) begin fails++; $display("FAIL single_result: got %h want 00030000", c); end
      tests_run++;
      if (tr - t != N + 3) begin fails++; $display("FAIL single_latency: got %0d want %0d", tr - t, N + 3); end
      tests_run++;
      if (resp_val !== 4'b0010 || grant_id !== 2'd1 || busy !== 1'b1) begin
         fails++; $display("FAIL single_resp_state: resp_val=%b gid=%0d busy=%b want 0010 1 1", resp_val, grant_id, busy);
      end
      exp_ptr = 2;
      @(negedge clk); #1;
      tests_run++;
      if (busy !== 1'b0 || resp_val !== 4'b0000) begin fails++; $display("FAIL single_done: busy=%b resp_val=%b want 0 0000", busy, resp_val); end
   endtask

   task automatic test_signed();
      int t, tr; logic [N-1:0] c; bit ok;
      run_op(0, 32'hFFFF_0000, 32'h0002_8000, t, tr, c, ok);
      tests_run++;
      if (!ok || c !== 32'hFFFD_8000 || resp_val !== 4'b0001) begin
         fails++; $display("FAIL signed_result: got %h on %b want fffd8000 on 0001", c, resp_val);
      end
      exp_ptr = 1;
   endtask

   task automatic test_backpressure();
      int t, tr, bad; logic [N-1:0] c, a, b, a0, b0; bit ok;
      a = N'($urandom); b = N'($urandom); a0 = N'($urandom); b0 = N'($urandom);
      resp_rdy = 4'b1011;
      run_op(2, a, b, t, tr, c, ok);
      tests_run++;
      if (!ok || c !== fx_mul(a, b)) begin fails++; $display("FAIL bp_result: got %h want %h", c, fx_mul(a, b)); end
      set_op(0, a0, b0);
      req_val = 4'b0001;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         if (resp_val !== 4'b0100 || resp_c !== fx_mul(a, b) || req_rdy !== 4'b0000) bad++;
      end
      tests_run++;
      if (bad != 0) begin fails++; $display("FAIL bp_stable: %0d unstable cycles, want 0", bad); end
      resp_rdy = '1;
      @(negedge clk); #1;
      exp_ptr = 3;
      tests_run++;
      if (resp_val !== 4'b0000 || req_rdy !== onehot(pick(4'b0001, exp_ptr))) begin
         fails++; $display("FAIL bp_release: resp_val=%b req_rdy=%b want 0000 0001", resp_val, req_rdy);
      end
      @(posedge clk); #1;
      req_val = '0;
      wait_resp(4'b0001, tr, ok);
      tests_run++;
      if (!ok || resp_c !== fx_mul(a0, b0)) begin fails++; $display("FAIL bp_next: got %h want %h", resp_c, fx_mul(a0, b0)); end
      exp_ptr = 1;
   endtask

   task automatic test_late_request();
      int t, tr, bad; logic [N-1:0] c, a, b, a3, b3; bit ok;
      a = N'($urandom); b = N'($urandom); a3 = N'($urandom); b3 = N'($urandom);
      tr = -1; c = '0;
      @(negedge clk);
      set_op(0, a, b); req_val = 4'b0001;
      wait_rdy(4'b0001, t, ok);
      @(posedge clk); #1;
      req_val = '0;
      while (cyc < t + 5) @(negedge clk);
      set_op(3, a3, b3); req_val = 4'b1000;
      bad = 0;
      while (cyc < t + N + 4) begin
         #1;
         if (req_rdy !== 4'b0000) bad++;
         if (resp_val === 4'b0001) begin tr = cyc; c = resp_c; end
         @(negedge clk);
      end
      #1;
      exp_ptr = 1;
      tests_run++;
      if (bad != 0) begin fails++; $display("FAIL late_blocked: req_rdy high in %0d busy cycles, want 0", bad); end
      tests_run++;
      if (tr - t != N + 3 || c !== fx_mul(a, b)) begin
         fails++; $display("FAIL late_first_resp: lat=%0d c=%h want lat=%0d c=%h", tr - t, c, N + 3, fx_mul(a, b));
      end
      tests_run++;
      if (req_rdy !== onehot(pick(4'b1000, exp_ptr))) begin fails++; $display("FAIL late_grant: req_rdy=%b want 1000", req_rdy); end
      @(posedge clk); #1;
      req_val = '0;
      wait_resp(4'b1000, tr, ok);
      tests_run++;
      if (!ok || resp_c !== fx_mul(a3, b3)) begin fails++; $display("FAIL late_second_resp: got %h want %h", resp_c, fx_mul(a3, b3)); end
      exp_ptr = 0;
   endtask

   task automatic test_random();
      logic [N-1:0] opa [NREQ];
      logic [N-1:0] opb [NREQ];
      logic [NREQ-1:0] mask;
      int t, tr, w; bit ok;
      for (int r = 0; r < 8; r++) begin
         @(negedge clk);
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            opa[i] = N'($urandom); opb[i] = N'($urandom); set_op(i, opa[i], opb[i]);
         end
         req_val = mask;
         wait_rdy(mask, t, ok);
         w = pick(mask, exp_ptr);
         tests_run++;
         if (!ok || req_rdy !== onehot(w)) begin fails++; $display("FAIL rand%0d_grant: mask=%b req_rdy=%b want %b", r, mask, req_rdy, onehot(w)); end
         @(posedge clk); #1;
         req_val = '0;
         tests_run++;
         if (grant_id !== IDW'(w) || busy !== 1'b1) begin fails++; $display("FAIL rand%0d_gid: gid=%0d busy=%b want %0d 1", r, grant_id, busy, w); end
         wait_resp(onehot(w), tr, ok);
         tests_run++;
         if (!ok || resp_c !== fx_mul(opa[w], opb[w]) || tr - t != N + 3) begin
            fails++; $display("FAIL rand%0d_resp: c=%h lat=%0d want c=%h lat=%0d", r, resp_c, tr - t, fx_mul(opa[w], opb[w]), N + 3);
         end
         exp_ptr = (w + 1) % NREQ;
      end
   endtask

   task automatic test_reset_mid_wait();
      int t, tr, seen, w; logic [N-1:0] c; bit ok;
      run_op(0, N'($urandom), N'($urandom), t, tr, c, ok);
      exp_ptr = 1;
      @(negedge clk);
      set_op(1, N'($urandom), N'($urandom)); req_val = 4'b0010;
      wait_rdy(4'b0010, t, ok);
      @(posedge clk); #1;
      req_val = '0;
      while (cyc < t + 10) @(negedge clk);
      reset = 1'b0;
      #1;
      tests_run++;
      if (mul_reset !== 1'b1 || busy !== 1'b0 || mul_send_rdy !== 1'b0 || grant_id !== 2'd0 || mul_a !== '0 || mul_b !== '0) begin
         fails++; $display("FAIL rst_during: mul_reset=%b busy=%b send_rdy=%b gid=%0d mul_a=%h mul_b=%h want 1 0 0 0 0 0",
                           mul_reset, busy, mul_send_rdy, grant_id, mul_a, mul_b);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      exp_ptr = 0;
      @(negedge clk); #1;
      tests_run++;
      if (busy !== 1'b0 || resp_val !== '0 || grant_id !== 2'd0 || mul_send_rdy !== 1'b0 || mul_recv_val !== 1'b0) begin
         fails++; $display("FAIL rst_after: busy=%b resp_val=%b gid=%0d send_rdy=%b recv_val=%b want all 0",
                           busy, resp_val, grant_id, mul_send_rdy, mul_recv_val);
      end
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (resp_val !== '0) seen++;
      end
      tests_run++;
      if (seen != 0) begin fails++; $display("FAIL rst_no_resp: resp_val seen %0d cycles, want 0", seen); end
      set_op(0, 32'h0001_0000, 32'h0001_0000); set_op(3, N'($urandom), N'($urandom));
      req_val = 4'b1001;
      wait_rdy(4'b1001, t, ok);
      w = pick(4'b1001, exp_ptr);
      tests_run++;
      if (!ok || req_rdy !== onehot(w)) begin fails++; $display("FAIL rst_ptr_cleared: req_rdy=%b want %b", req_rdy, onehot(w)); end
      @(posedge clk); #1;
      req_val = '0;
      wait_resp(onehot(w), tr, ok);
      tests_run++;
      if (!ok || resp_c !== 32'h0001_0000 || tr - t != N + 3) begin
         fails++; $display("FAIL rst_new_op: c=%h lat=%0d want 00010000 %0d", resp_c, tr - t, N + 3);
      end
      exp_ptr = (w + 1) % NREQ;
   endtask

   initial begin
      reset = 1'b0; req_val = '0; req_a = '0; req_b = '0; resp_rdy = '1;
      test_reset();
      test_contention();
      test_single();
      test_signed();
      test_backpressure();
      test_late_request();
      test_random();
      test_reset_mid_wait();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule

// File: doc/fxp_mult_arbiter.md
# fxp_mult_arbiter

Round-robin arbiter and sequencer that shares one `fixed_point_iterative_Multiplier` among `NREQ` requesters. It accepts one operand pair at a time over per-requester val/rdy channels and issues it to the multiplier. It then collects the product and returns it on the winning requester's response channel. The block sits between the requesting units and the single multiplier instance, and at most one operation is in flight.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `N`, 32: operand/result width; must equal the multiplier's `n`.

- `clk` in 1: clock; all state changes on posedge.
- `reset` in 1: synchronous, active-low; low at a posedge clears all state.
- `req_val` in NREQ: request valid, one bit per requester.
- `req_rdy` out NREQ: request accepted; one-hot or zero.
- `req_a` in NREQ*N: operand a, requester i at bits [i*N +: N].
- `req_b` in NREQ*N: operand b, same packing.
- `resp_val` out NREQ: result valid; one-hot or zero.
- `resp_rdy` in NREQ: result consumed.
- `resp_c` out N: shared result bus, valid only with `resp_val`.
- `mul_reset` out 1: `!reset`; drives the multiplier's active-high reset.
- `mul_recv_val` out 1, `mul_recv_rdy` in 1, `mul_a` out N, `mul_b` out N: multiplier request side.
- `mul_send_val` in 1, `mul_send_rdy` out 1, `mul_c` in N: multiplier response side.
- `busy` out 1: state != IDLE.
- `grant_id` out clog2(NREQ): index of the current or last winner.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - The arbiter picks the winner among `req_val` bits, starting at `ptr` and wrapping modulo `NREQ`.
  - `req_rdy[winner]` is driven combinationally in the same cycle.
  - On that handshake it latches `req_a`/`req_b` slices into `op_a`/`op_b` and the winner into `id`, then moves to ISSUE.
  - With no `req_val` it stays in IDLE and `req_rdy` is all zero.
- **ISSUE**
  - `mul_recv_val`=1; `mul_a`=`op_a`, `mul_b`=`op_b`.
  - On `mul_recv_rdy`, moves to WAIT.
  - `mul_a`/`mul_b` hold `op_a`/`op_b` in every state; the multiplier only samples them in its IDLE.
- **WAIT**
  - `mul_send_rdy`=1.
  - On `mul_send_val`, latches `mul_c` into `res` and moves to RESP.
- **RESP**
  - `resp_val[id]`=1; `resp_c`=`res`.
  - On `resp_rdy[id]`: `ptr` <= (`id`+1) mod `NREQ`, then move to IDLE.
  - `resp_rdy` of other indices is ignored.
- Requests arriving in ISSUE, WAIT or RESP are not accepted (`req_rdy`=0). They wait; no queue.
- No arithmetic is done in this block. Products use the multiplier's fixed-point format unchanged.
- Reset mid-operation:
  - FSM goes to IDLE, `ptr`=0, `id`=0, `op_a`/`op_b`/`res`=0.
  - `mul_reset` aborts the multiplier in the same cycle.
  - The in-flight result is discarded and no response is produced.

## Timing
- Reset values (also driven while `reset` is low): `req_rdy`=0, `resp_val`=0, `resp_c`=0, `mul_recv_val`=0, `mul_send_rdy`=0, `mul_a`=`mul_b`=0, `busy`=0, `grant_id`=0.
- Request handshake in cycle T with the multiplier idle and `resp_rdy` held high:
  - ISSUE is in T+1.
  - The multiplier computes in T+2..T+N+1.
  - `mul_send_val` is seen in T+N+2.
  - `resp_val` is in T+N+3.
  - The next request can be accepted in T+N+4.
- Throughput: one operation per N+4 cycles.
- Combinational paths:
  - `req_val` to `req_rdy` (arbitration).
  - No path from `resp_rdy` or `mul_*` inputs to any output except through registered state.
- `resp_val`, `resp_c` and `mul_recv_val` are held stable until their handshake completes.

## Configuration
- `FXP_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest asserted `req_val` index always wins; `ptr` is not implemented.
  - Undefined (default): round-robin as above; every continuously requesting requester is granted within `NREQ` grants.

## Test plan
- Single op: `req_val[1]`, a=0x00018000 (1.5), b=0x00020000 (2.0) -> `resp_val[1]` at T+35, `resp_c`=0x00030000.
- Signed op: `req_val[0]`, a=0xFFFF0000 (-1.0), b=0x00028000 (2.5) -> `resp_c`=0xFFFD8000 on `resp_val[0]`.
- Contention: `req_val`=4'b1111 held high from reset -> grant order 0,1,2,3,0. With `FXP_ARB_FIXED_PRIO_EN` defined -> 0,0,0.
- Backpressure: `resp_rdy[2]`=0 for 10 cycles -> `resp_val[2]` and `resp_c` stay stable; `req_rdy`=0 throughout; completes the cycle `resp_rdy[2]` rises.
- Reset mid-WAIT: `reset` low for 1 cycle at T+10 -> all outputs at reset values next cycle, no `resp_val`. A new request at a=0x00010000, b=0x00010000 then returns 0x00010000.
- Late request: `req_val[3]` rises during WAIT of requester 0 -> `req_rdy[3]`=0 until IDLE, then granted in the first IDLE cycle.
